alarm_clock_multi: RTL and testbench
====================================

ALARM_CLOCK_MULTI -- requirements
Module: alarm_clock_multi

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 10, clk cycles per second (>=2).
REQ-002 SHALL provide parameter NUM_ALARMS, default 4, number of alarm slots (1..16).
REQ-003 SHALL provide parameter SNOOZE_SEC, default 300, snooze duration in seconds.
REQ-004 SHALL provide parameter RING_SEC, default 60, ring timeout in seconds.
REQ-005 SHALL provide ports:
- clk  in  1  system clock; one clock; reset is asynchronous and active-low
- reset_n  in  1  asynchronous active-low reset
- h_in1 in 2 / h_in0 in 4 / m_in1 in 4 / m_in0 in 4  BCD load value HH:MM
- ld_time  in  1  load time of day
- ld_alarm  in  1  load alarm slot al_sel
- al_sel  in  max(1,$clog2(NUM_ALARMS))  slot index for ld_alarm
- al_en  in  NUM_ALARMS  per-slot enable
- stop_al  in  1  stop ringing/snooze
- snooze  in  1  snooze request
- alarm  out  1  ringing indicator
- alarm_id  out  max(1,$clog2(NUM_ALARMS))  slot that triggered
- tick_1s  out  1  one-clk pulse per second
- h_out1 2, h_out0 4, m_out1 4, m_out0 4, s_out1 4, s_out0 4  out  BCD time

Function
REQ-006 Prescaler SHALL count 0..CLK_DIV-1; tick_1s SHALL pulse high for the clk cycle where count==CLK_DIV-1.
REQ-007 Time SHALL be held as BCD digit counters and advance one second per tick; 09->10 digit carry, 59 s->00 with minute carry, 59 min->00 with hour carry, 23:59:59->00:00:00.
REQ-008 ld_time with valid input (hour<=23, minute<=59, every digit<=9) SHALL load HH:MM:00 and clear the prescaler next edge; ld_time SHALL win over a same-cycle tick.
REQ-009 Invalid ld_time or ld_alarm values SHALL be ignored entirely (no state change).
REQ-010 ld_alarm SHALL write HH:MM to slot al_sel; al_sel>=NUM_ALARMS SHALL be ignored; ld_time and ld_alarm together SHALL both take effect.
REQ-011 Match SHALL be evaluated on the clk edge after time changes (tick or load): slot i matches when al_en[i] and time==slot HH:MM:00; lowest matching index wins.
REQ-012 Alarm FSM states IDLE, RINGING, SNOOZED; alarm=1 only in RINGING.
REQ-013 IDLE->RINGING on match; alarm_id SHALL latch winning index and ring counter load RING_SEC.
REQ-014 RINGING: matches SHALL be ignored; ring counter decrements per tick; reaching 0 ->IDLE.
REQ-015 RINGING->SNOOZED on snooze; snooze counter loads SNOOZE_SEC, decrements per tick; reaching 0 ->RINGING, same alarm_id, ring counter reloaded.
REQ-016 stop_al in RINGING or SNOOZED ->IDLE next edge; stop_al SHALL win over simultaneous snooze.
REQ-017 Clearing al_en[alarm_id] in RINGING or SNOOZED SHALL force IDLE next edge.
REQ-018 ld_time SHALL not alter FSM state or counters.

Reset
REQ-019 reset_n low SHALL immediately clear time to 00:00:00, all slots to 00:00, prescaler, counters, state IDLE, alarm=0, alarm_id=0, tick_1s=0.
REQ-020 Reset mid-ring or mid-snooze SHALL abandon the alarm; no ring after release until a new match.

Configuration
REQ-021 Macro ALARM_SNOOZE_EN defined: SNOOZED state and snooze input behave per REQ-015.
REQ-022 ALARM_SNOOZE_EN undefined: SNOOZED state and snooze counter SHALL not exist; snooze input ignored; port list unchanged.

Verification
REQ-023 CLK_DIV=10: release reset, 10*86400 clk -> time returns 00:00:00; after 599 ticks display 00:09:59, next tick 00:10:00.
REQ-024 ld_time 23:59, 60 ticks -> 00:00:00; ld_time 24:00 or 12:6A -> time unchanged.
REQ-025 Slots 1 and 2 both 07:30, al_en=4'b0110, ld_time 07:29, 60 ticks -> alarm=1, alarm_id=1; RING_SEC ticks later alarm=0.
REQ-026 With ALARM_SNOOZE_EN, SNOOZE_SEC=5: ringing, pulse snooze -> alarm=0, 5 ticks later alarm=1 same id; pulse snooze+stop_al together -> IDLE, no re-ring.
REQ-027 Ringing, drop reset_n mid-cycle -> alarm=0 and time 00:00:00 immediately; without ALARM_SNOOZE_EN snooze pulse leaves alarm=1.

Source files
------------

// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi
//   24-hour BCD time-of-day clock with NUM_ALARMS programmable HH:MM alarm slots.
//   A prescaler divides clk down to a one-second tick. Time advances on each tick.
//   When the time changes (by a tick or by a load), the enabled slots are compared
//   against HH:MM:00 on the following edge. The lowest matching slot starts ringing.
//   Ringing stops after RING_SEC seconds, on stop_al, or when the slot's enable drops.
//
// Configuration macro:
//   ALARM_SNOOZE_EN - when defined, a snooze request while ringing silences the
//                     alarm for SNOOZE_SEC seconds, after which it rings again with
//                     the same alarm_id. When undefined, snooze is ignored.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   h_in1,h_in0,m_in1,m_in0    BCD HH:MM load value shared by ld_time / ld_alarm
//   ld_time                    load time of day (seconds cleared, prescaler cleared)
//   ld_alarm, al_sel           load HH:MM into alarm slot al_sel
//   al_en                      per-slot alarm enable
//   stop_al, snooze            user controls while ringing / snoozed
//   alarm, alarm_id            ringing indicator and the slot that triggered it
//   tick_1s                    one-clk pulse per second
//   h_out1..s_out0             BCD time of day HH:MM:SS
module alarm_clock_multi #(
    parameter int CLK_DIV    = 10,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            h_in1,
    input  logic [3:0]            h_in0,
    input  logic [3:0]            m_in1,
    input  logic [3:0]            m_in0,
    input  logic                  ld_time,
    input  logic                  ld_alarm,
    input  logic [AW-1:0]         al_sel,
    input  logic [NUM_ALARMS-1:0] al_en,
    input  logic                  stop_al,
    input  logic                  snooze,
    output logic                  alarm,
    output logic [AW-1:0]         alarm_id,
    output logic                  tick_1s,
    output logic [1:0]            h_out1,
    output logic [3:0]            h_out0,
    output logic [3:0]            m_out1,
    output logic [3:0]            m_out0,
    output logic [3:0]            s_out1,
    output logic [3:0]            s_out0
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC + 1) : 1;
    localparam logic [AW:0] NUM_SLOTS = (AW + 1)'(NUM_ALARMS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
        , SNOOZED = 2'd2
`endif
    } state_t;

    // A BCD HH:MM value is usable only if every digit is decimal and it is a real time.
    function automatic logic hhmm_valid(input logic [1:0] h1, input logic [3:0] h0,
                                        input logic [3:0] m1, input logic [3:0] m0);
        logic hour_ok;
        hour_ok = ((h1 < 2'd2) && (h0 <= 4'd9)) || ((h1 == 2'd2) && (h0 <= 4'd3));
        return hour_ok && (m1 <= 4'd5) && (m0 <= 4'd9);
    endfunction

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic          time_chg_r;
    logic          in_valid_s;
    logic          time_load_s;
    logic          alarm_load_s;
    logic [1:0]    nh1_s;
    logic [3:0]    nh0_s, nm1_s, nm0_s, ns1_s, ns0_s;
    logic [1:0]    al_h1_r [NUM_ALARMS];
    logic [3:0]    al_h0_r [NUM_ALARMS];
    logic [3:0]    al_m1_r [NUM_ALARMS];
    logic [3:0]    al_m0_r [NUM_ALARMS];
    logic          hit_s;
    logic          match_s;
    logic [AW-1:0] match_id_s;
    state_t        state_r;
    logic [RW-1:0] ring_cnt_r;
`ifdef ALARM_SNOOZE_EN
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC + 1) : 1;
    logic [SW-1:0] snz_cnt_r;
`else
    logic          unused_snooze_s;
    assign unused_snooze_s = snooze;
`endif

    assign in_valid_s   = hhmm_valid(h_in1, h_in0, m_in1, m_in0);
    assign time_load_s  = ld_time && in_valid_s;
    assign alarm_load_s = ld_alarm && in_valid_s && ({1'b0, al_sel} < NUM_SLOTS);

    // Prescaler successor value: wraps at CLK_DIV-1.
    always_comb begin
        if (presc_r == PW'(CLK_DIV - 1)) begin
            presc_nxt_s = {PW{1'b0}};
        end else begin
            presc_nxt_s = presc_r + PW'(1);
        end
    end

    // Time-of-day successor: ripple BCD carry through seconds, minutes and hours.
    always_comb begin
        nh1_s = h_out1;
        nh0_s = h_out0;
        nm1_s = m_out1;
        nm0_s = m_out0;
        ns1_s = s_out1;
        ns0_s = s_out0;
        if (s_out0 == 4'd9) begin
            ns0_s = 4'd0;
            if (s_out1 == 4'd5) begin
                ns1_s = 4'd0;
                if (m_out0 == 4'd9) begin
                    nm0_s = 4'd0;
                    if (m_out1 == 4'd5) begin
                        nm1_s = 4'd0;
                        if ((h_out1 == 2'd2) && (h_out0 == 4'd3)) begin
                            nh1_s = 2'd0;
                            nh0_s = 4'd0;
                        end else if (h_out0 == 4'd9) begin
                            nh1_s = h_out1 + 2'd1;
                            nh0_s = 4'd0;
                        end else begin
                            nh0_s = h_out0 + 4'd1;
                        end
                    end else begin
                        nm1_s = m_out1 + 4'd1;
                    end
                end else begin
                    nm0_s = m_out0 + 4'd1;
                end
            end else begin
                ns1_s = s_out1 + 4'd1;
            end
        end else begin
            ns0_s = s_out0 + 4'd1;
        end
    end

    // Prescaler, tick and time-of-day registers; a valid load beats a same-cycle tick.
    // tick_1s is registered one cycle early so it is high exactly while presc_r==CLK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r    <= {PW{1'b0}};
            tick_1s    <= 1'b0;
            time_chg_r <= 1'b0;
            h_out1     <= 2'd0;
            h_out0     <= 4'd0;
            m_out1     <= 4'd0;
            m_out0     <= 4'd0;
            s_out1     <= 4'd0;
            s_out0     <= 4'd0;
        end else begin
            time_chg_r <= time_load_s || tick_1s;
            if (time_load_s) begin
                presc_r <= {PW{1'b0}};
                tick_1s <= 1'b0;
                h_out1  <= h_in1;
                h_out0  <= h_in0;
                m_out1  <= m_in1;
                m_out0  <= m_in0;
                s_out1  <= 4'd0;
                s_out0  <= 4'd0;
            end else begin
                presc_r <= presc_nxt_s;
                tick_1s <= (presc_nxt_s == PW'(CLK_DIV - 1));
                if (tick_1s) begin
                    h_out1 <= nh1_s;
                    h_out0 <= nh0_s;
                    m_out1 <= nm1_s;
                    m_out0 <= nm0_s;
                    s_out1 <= ns1_s;
                    s_out0 <= ns0_s;
                end
            end
        end
    end

    // Alarm slot storage, written by a valid ld_alarm to an existing slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_h1_r[i] <= 2'd0;
                al_h0_r[i] <= 4'd0;
                al_m1_r[i] <= 4'd0;
                al_m0_r[i] <= 4'd0;
            end
        end else if (alarm_load_s) begin
            al_h1_r[al_sel] <= h_in1;
            al_h0_r[al_sel] <= h_in0;
            al_m1_r[al_sel] <= m_in1;
            al_m0_r[al_sel] <= m_in0;
        end
    end

    // Slot comparison; scanning from the top down leaves the lowest matching index.
    always_comb begin
        hit_s      = 1'b0;
        match_s    = 1'b0;
        match_id_s = {AW{1'b0}};
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            hit_s = al_en[i] && (al_h1_r[i] == h_out1) && (al_h0_r[i] == h_out0) &&
                    (al_m1_r[i] == m_out1) && (al_m0_r[i] == m_out0) &&
                    (s_out1 == 4'd0) && (s_out0 == 4'd0);
            match_s    = match_s | hit_s;
            match_id_s = hit_s ? AW'(i) : match_id_s;
        end
    end

    // Alarm state machine with registered alarm / alarm_id outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            alarm      <= 1'b0;
            alarm_id   <= {AW{1'b0}};
            ring_cnt_r <= {RW{1'b0}};
`ifdef ALARM_SNOOZE_EN
            snz_cnt_r  <= {SW{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (time_chg_r && match_s) begin
                        state_r    <= RINGING;
                        alarm      <= 1'b1;
                        alarm_id   <= match_id_s;
                        ring_cnt_r <= RW'(RING_SEC);
                    end
                end
                RINGING: begin
                    if (!al_en[alarm_id] || stop_al) begin
                        state_r <= IDLE;
                        alarm   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_r   <= SNOOZED;
                        alarm     <= 1'b0;
                        snz_cnt_r <= SW'(SNOOZE_SEC);
`endif
                    end else if (tick_1s) begin
                        if (ring_cnt_r <= RW'(1)) begin
                            state_r    <= IDLE;
                            alarm      <= 1'b0;
                            ring_cnt_r <= {RW{1'b0}};
                        end else begin
                            ring_cnt_r <= ring_cnt_r - RW'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZED: begin
                    if (!al_en[alarm_id] || stop_al) begin
                        state_r <= IDLE;
                        alarm   <= 1'b0;
                    end else if (tick_1s) begin
                        if (snz_cnt_r <= SW'(1)) begin
                            state_r    <= RINGING;
                            alarm      <= 1'b1;
                            snz_cnt_r  <= {SW{1'b0}};
                            ring_cnt_r <= RW'(RING_SEC);
                        end else begin
                            snz_cnt_r <= snz_cnt_r - SW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi (CLK_DIV=4, 4 slots, RING_SEC=3, SNOOZE_SEC=5).
// Expected observations {HHMMSS, alarm, alarm_id} are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled on the falling clock edge.
module tb_alarm_clock_multi;

    localparam int CLK_DIV    = 4;
    localparam int NUM_ALARMS = 4;
    localparam int SNOOZE_SEC = 5;
    localparam int RING_SEC   = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] h_in1 = 2'd0;
    logic [3:0] h_in0 = 4'd0, m_in1 = 4'd0, m_in0 = 4'd0;
    logic       ld_time = 1'b0, ld_alarm = 1'b0;
    logic [1:0] al_sel = 2'd0;
    logic [3:0] al_en = 4'd0;
    logic       stop_al = 1'b0, snooze = 1'b0;
    logic       alarm, tick_1s;
    logic [1:0] alarm_id;
    logic [1:0] h_out1;
    logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    logic [31:0] obs_v;

    assign obs_v = {2'b00, h_out1, h_out0, m_out1, m_out0, s_out1, s_out0,
                    3'b000, alarm, 2'b00, alarm_id};

    alarm_clock_multi #(
        .CLK_DIV(CLK_DIV), .NUM_ALARMS(NUM_ALARMS), .SNOOZE_SEC(SNOOZE_SEC), .RING_SEC(RING_SEC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .h_in1(h_in1), .h_in0(h_in0), .m_in1(m_in1), .m_in0(m_in0),
        .ld_time(ld_time), .ld_alarm(ld_alarm), .al_sel(al_sel), .al_en(al_en),
        .stop_al(stop_al), .snooze(snooze),
        .alarm(alarm), .alarm_id(alarm_id), .tick_1s(tick_1s),
        .h_out1(h_out1), .h_out0(h_out0), .m_out1(m_out1), .m_out0(m_out0),
        .s_out1(s_out1), .s_out0(s_out0)
    );

    always #5 clk = ~clk;

    // Expected observation word: HH MM SS digits, alarm, alarm_id (one hex digit each).
    function automatic logic [31:0] exp_of(input int h, input int m, input int s,
                                           input int a, input int id);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(a), 4'(id)};
    endfunction

    // Advance n seconds; returns on the falling edge right after the n-th tick edge.
    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int guard;
            guard = 0;
            while (!tick_1s && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!tick_1s) begin
                checks++;
                errors++;
                $display("FAIL tick_timeout: no tick_1s after %0d cycles, required one", guard);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_time(input logic [1:0] h1, input logic [3:0] h0,
                             input logic [3:0] m1, input logic [3:0] m0);
        h_in1 = h1; h_in0 = h0; m_in1 = m1; m_in0 = m0;
        ld_time = 1'b1;
        @(negedge clk);
        ld_time = 1'b0;
    endtask

    task automatic load_alarm(input logic [1:0] sel, input logic [1:0] h1, input logic [3:0] h0,
                              input logic [3:0] m1, input logic [3:0] m0);
        h_in1 = h1; h_in0 = h0; m_in1 = m1; m_in0 = m0;
        al_sel = sel;
        ld_alarm = 1'b1;
        @(negedge clk);
        ld_alarm = 1'b0;
    endtask

    // Load 07:29 and run into the 07:30 match; returns one edge after the match edge.
    task automatic ring_up;
        load_time(2'd0, 4'd7, 4'd2, 4'd9);
        wait_ticks(60);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.push_back(exp_of(0, 0, 0, 0, 0));
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_state: got %h, required %h", obs_v, exp_v); end
        checks++;
        if (tick_1s !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, required 0", tick_1s); end
        reset_n = 1'b1;
    endtask

    task automatic test_count;
        int cnt;
        sb_q.push_back(exp_of(0, 9, 59, 0, 0));
        wait_ticks(599);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL count_599: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(0, 10, 0, 0, 0));
        wait_ticks(1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL count_600: got %h, required %h", obs_v, exp_v); end
        cnt = 0;
        while (!tick_1s && cnt < 50) begin @(negedge clk); cnt++; end
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!tick_1s && cnt < 50);
        checks++;
        if (cnt != CLK_DIV) begin errors++; $display("FAIL tick_period: got %0d cycles, required %0d", cnt, CLK_DIV); end
    endtask

    task automatic test_load;
        int cnt;
        load_time(2'd2, 4'd3, 4'd5, 4'd9);
        cnt = 1;
        while (!tick_1s && cnt < 50) begin @(negedge clk); cnt++; end
        checks++;
        if (cnt != CLK_DIV) begin errors++; $display("FAIL presc_clear_on_load: first tick at cycle %0d, required %0d", cnt, CLK_DIV); end
        sb_q.push_back(exp_of(0, 0, 0, 0, 0));
        wait_ticks(60);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL wrap_midnight: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(0, 0, 0, 0, 0));
        load_time(2'd2, 4'd4, 4'd0, 4'd0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ld_invalid_hour: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(0, 0, 0, 0, 0));
        load_time(2'd1, 4'd2, 4'd6, 4'd10);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ld_invalid_min: got %h, required %h", obs_v, exp_v); end
        cnt = 0;
        while (!tick_1s && cnt < 50) begin @(negedge clk); cnt++; end
        sb_q.push_back(exp_of(10, 20, 0, 0, 0));
        load_time(2'd1, 4'd0, 4'd2, 4'd0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ld_beats_tick: got %h, required %h", obs_v, exp_v); end
    endtask

    task automatic test_alarm;
        al_en = 4'b0110;
        load_alarm(2'd0, 2'd0, 4'd7, 4'd3, 4'd0);
        load_alarm(2'd1, 2'd0, 4'd7, 4'd3, 4'd0);
        load_alarm(2'd2, 2'd0, 4'd7, 4'd3, 4'd0);
        load_alarm(2'd1, 2'd0, 4'd7, 4'd7, 4'd10);
        load_time(2'd0, 4'd7, 4'd2, 4'd9);
        sb_q.push_back(exp_of(7, 30, 0, 0, 0));
        wait_ticks(60);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL match_next_edge: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(7, 30, 0, 1, 1));
        @(negedge clk);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ring_lowest_enabled: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(7, 30, RING_SEC - 1, 1, 1));
        wait_ticks(RING_SEC - 1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ring_before_timeout: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(7, 30, RING_SEC, 0, 1));
        wait_ticks(1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ring_timeout: got %h, required %h", obs_v, exp_v); end
        // Simultaneous time and alarm load: the load itself makes the match.
        al_en = 4'b1000;
        h_in1 = 2'd0; h_in0 = 4'd9; m_in1 = 4'd1; m_in0 = 4'd5; al_sel = 2'd3;
        ld_time = 1'b1; ld_alarm = 1'b1;
        sb_q.push_back(exp_of(9, 15, 0, 0, 1));
        @(negedge clk);
        ld_time = 1'b0; ld_alarm = 1'b0;
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL combo_load_time: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(9, 15, 0, 1, 3));
        @(negedge clk);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL combo_load_alarm: got %h, required %h", obs_v, exp_v); end
        stop_al = 1'b1;
        sb_q.push_back(exp_of(9, 15, 0, 0, 3));
        @(negedge clk);
        stop_al = 1'b0;
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL stop_ringing: got %h, required %h", obs_v, exp_v); end
        al_en = 4'b0110;
    endtask

    task automatic test_stop;
        sb_q.push_back(exp_of(7, 30, 0, 1, 1));
        ring_up();
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ring_again: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(12, 0, 0, 1, 1));
        load_time(2'd1, 4'd2, 4'd0, 4'd0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ld_time_keeps_ring: got %h, required %h", obs_v, exp_v); end
        stop_al = 1'b1;
        sb_q.push_back(exp_of(12, 0, 0, 0, 1));
        @(negedge clk);
        stop_al = 1'b0;
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL stop_after_load: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(12, 0, RING_SEC + 1, 0, 1));
        wait_ticks(RING_SEC + 1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL stays_stopped: got %h, required %h", obs_v, exp_v); end
    endtask

    task automatic test_en_clear;
        ring_up();
        al_en = 4'b0100;
        sb_q.push_back(exp_of(7, 30, 0, 0, 1));
        @(negedge clk);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL en_clear_idle: got %h, required %h", obs_v, exp_v); end
        al_en = 4'b0110;
    endtask

    task automatic test_snooze;
        ring_up();
        snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
        sb_q.push_back(exp_of(7, 30, 0, 0, 1));
        @(negedge clk);
        snooze = 1'b0;
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL snooze_silences: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(7, 30, SNOOZE_SEC - 1, 0, 1));
        wait_ticks(SNOOZE_SEC - 1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL snooze_holding: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(7, 30, SNOOZE_SEC, 1, 1));
        wait_ticks(1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL snooze_rering: got %h, required %h", obs_v, exp_v); end
        snooze = 1'b1; stop_al = 1'b1;
        sb_q.push_back(exp_of(7, 30, SNOOZE_SEC, 0, 1));
        @(negedge clk);
        snooze = 1'b0; stop_al = 1'b0;
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL stop_beats_snooze: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(7, 30, SNOOZE_SEC + 8, 0, 1));
        wait_ticks(8);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL no_rering_after_stop: got %h, required %h", obs_v, exp_v); end
`else
        sb_q.push_back(exp_of(7, 30, 0, 1, 1));
        @(negedge clk);
        snooze = 1'b0;
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL snooze_ignored: got %h, required %h", obs_v, exp_v); end
        sb_q.push_back(exp_of(7, 30, RING_SEC, 0, 1));
        wait_ticks(RING_SEC);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL ring_timeout_nosnooze: got %h, required %h", obs_v, exp_v); end
`endif
    endtask

    task automatic test_reset_mid_ring;
        ring_up();
        #2;
        reset_n = 1'b0;
        sb_q.push_back(exp_of(0, 0, 0, 0, 0));
        #1;
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_mid_ring: got %h, required %h", obs_v, exp_v); end
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back(exp_of(0, 0, 3, 0, 0));
        wait_ticks(3);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL no_ring_after_reset: got %h, required %h", obs_v, exp_v); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_load();
        test_alarm();
        test_stop();
        test_en_clear();
        test_snooze();
        test_reset_mid_ring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound in case the run stalls somewhere unexpected.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

endmodule
